// File: rtl/jt10_adpcm_romif.sv
// rtl/jt10_adpcm_romif.sv - ADPCM-A/B ROM read arbiter onto a single memory port
// Each client keeps a one-entry address tag; a changed address queues a fetch.
module jt10_adpcm_romif #(
    parameter logic [24:0] A_BASE = 25'h000_0000,
    parameter logic [24:0] B_BASE = 25'h100_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] adpcma_addr,
    input  logic [3:0]  adpcma_bank,
    input  logic        adpcma_roe_n,
    output logic [7:0]  adpcma_data,
    input  logic [23:0] adpcmb_addr,
    input  logic        adpcmb_roe_n,
    output logic [7:0]  adpcmb_data,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_A = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [23:0] a_full;
    logic [23:0] last_a;
    logic [23:0] last_b;
    logic        vld_a;
    logic        vld_b;
    logic        pend_a;
    logic        pend_b;
    logic        last_srv_b;
    logic        change_a;
    logic        change_b;
    logic        enter_a;
    logic        enter_b;
    logic        done_a;
    logic        done_b;

    assign a_full   = {adpcma_bank, adpcma_addr};
    assign change_a = ~adpcma_roe_n & (~vld_a | (a_full != last_a));
    assign change_b = ~adpcmb_roe_n & (~vld_b | (adpcmb_addr != last_b));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin on a tie: the client not served last goes first.
    always_comb begin
        state_nxt = state;
        enter_a   = 1'b0;
        enter_b   = 1'b0;
        done_a    = 1'b0;
        done_b    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_a && (!pend_b || last_srv_b)) begin
                    enter_a   = 1'b1;
                    state_nxt = WAIT_A;
                end else if (pend_b) begin
                    enter_b   = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_A: begin
                if (mem_ack) begin
                    done_a    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_B: begin
                if (mem_ack) begin
                    done_b    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A fresh address change outranks the pending-clear of the fetch just started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a <= 24'd0;
            last_b <= 24'd0;
            vld_a  <= 1'b0;
            vld_b  <= 1'b0;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            if (change_a) begin
                last_a <= a_full;
                vld_a  <= 1'b1;
                pend_a <= 1'b1;
            end else if (enter_a) begin
                pend_a <= 1'b0;
            end
            if (change_b) begin
                last_b <= adpcmb_addr;
                vld_b  <= 1'b1;
                pend_b <= 1'b1;
            end else if (enter_b) begin
                pend_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req     <= 1'b0;
            mem_addr    <= 25'd0;
            last_srv_b  <= 1'b1;
            adpcma_data <= 8'd0;
            adpcmb_data <= 8'd0;
        end else begin
            if (enter_a) begin
                mem_req    <= 1'b1;
                mem_addr   <= A_BASE + {1'b0, last_a};
                last_srv_b <= 1'b0;
            end else if (enter_b) begin
                mem_req    <= 1'b1;
                mem_addr   <= B_BASE + {1'b0, last_b};
                last_srv_b <= 1'b1;
            end else if (done_a || done_b) begin
                mem_req <= 1'b0;
            end
            if (done_a) begin
                adpcma_data <= mem_data;
            end
            if (done_b) begin
                adpcmb_data <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_romif.sv
// tb/tb_jt10_adpcm_romif.sv - directed scoreboard bench for jt10_adpcm_romif
module tb_jt10_adpcm_romif;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] adpcma_addr = 20'd0;
    logic [3:0]  adpcma_bank = 4'd0;
    logic        adpcma_roe_n = 1'b1;
    logic [7:0]  adpcma_data;
    logic [23:0] adpcmb_addr = 24'd0;
    logic        adpcmb_roe_n = 1'b1;
    logic [7:0]  adpcmb_data;
    logic        mem_req;
    logic [24:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'd0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [24:0] exp_q[$];
    logic [24:0] cur_addr;
    int          pulses;
    logic        prev_req;

    jt10_adpcm_romif #(
        .A_BASE(25'h000_0000),
        .B_BASE(25'h100_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .adpcma_addr(adpcma_addr),
        .adpcma_bank(adpcma_bank),
        .adpcma_roe_n(adpcma_roe_n),
        .adpcma_data(adpcma_data),
        .adpcmb_addr(adpcmb_addr),
        .adpcmb_roe_n(adpcmb_roe_n),
        .adpcmb_data(adpcmb_data),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Waits for mem_req, then pops the scoreboard and compares the address.
    task automatic wait_req(input string tag);
        logic [24:0] e;
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) break;
            @(negedge clk);
        end
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            e = 25'd0;
        end else begin
            e = exp_q.pop_front();
        end
        cur_addr = e;
        check({tag, "_addr"}, {7'd0, mem_addr}, {7'd0, e});
    endtask

    // Holds off for 'delay' cycles checking request stability, then acks once.
    task automatic do_ack(input string tag, input logic [7:0] d, input int delay);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check({tag, "_hold_req"}, {31'd0, mem_req}, 32'd1);
            check({tag, "_hold_addr"}, {7'd0, mem_addr}, {7'd0, cur_addr});
        end
        mem_ack  = 1'b1;
        mem_data = d;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", {7'd0, mem_addr}, 32'd0);
        check("rst_da", {24'd0, adpcma_data}, 32'd0);
        check("rst_db", {24'd0, adpcmb_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // A fetch with latency check: pend at N, request only after N+1
        adpcma_bank  = 4'h2;
        adpcma_addr  = 20'h00010;
        adpcma_roe_n = 1'b0;
        exp_q.push_back(25'h020_0010);
        @(negedge clk);
        check("a_lat_req_low", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        check("a_lat_req_high", {31'd0, mem_req}, 32'd1);
        wait_req("a1");
        do_ack("a1", 8'h5A, 3);
        check("a1_data", {24'd0, adpcma_data}, 32'h5A);

        // Same address again: no new request
        pulses = 0;
        prev_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_req && !prev_req) pulses++;
            prev_req = mem_req;
        end
        check("a_hit_pulses", pulses, 0);
        check("a_hit_data", {24'd0, adpcma_data}, 32'h5A);

        // Address changes with roe_n high are ignored
        adpcma_roe_n = 1'b1;
        adpcma_addr  = 20'h00777;
        repeat (4) @(negedge clk);
        check("roe_hi_req", {31'd0, mem_req}, 32'd0);

        // B fetch at top of region
        adpcmb_addr  = 24'hFF_FFFF;
        adpcmb_roe_n = 1'b0;
        exp_q.push_back(25'h1FF_FFFF);
        @(negedge clk);
        wait_req("b1");
        do_ack("b1", 8'hC3, 2);
        check("b1_data", {24'd0, adpcmb_data}, 32'hC3);
        check("b1_a_kept", {24'd0, adpcma_data}, 32'h5A);
        adpcmb_roe_n = 1'b1;

        // Stale ack in IDLE is ignored
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        @(negedge clk);
        mem_ack  = 1'b0;
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        check("idle_ack_da", {24'd0, adpcma_data}, 32'h5A);
        check("idle_ack_db", {24'd0, adpcmb_data}, 32'hC3);

        // Reset, then simultaneous A (address 0) and B changes
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        adpcma_bank  = 4'h0;
        adpcma_addr  = 20'h00000;
        adpcmb_addr  = 24'h00_0123;
        adpcma_roe_n = 1'b0;
        adpcmb_roe_n = 1'b0;
        exp_q.push_back(25'h000_0000);
        exp_q.push_back(25'h100_0123);
        @(negedge clk);
        wait_req("sim_a");
        do_ack("sim_a", 8'h11, 1);
        @(negedge clk);
        wait_req("sim_b");
        do_ack("sim_b", 8'h22, 1);
        check("sim_da", {24'd0, adpcma_data}, 32'h11);
        check("sim_db", {24'd0, adpcmb_data}, 32'h22);
        adpcmb_roe_n = 1'b1;

        // Reset while waiting on A, then a stale ack
        adpcma_addr = 20'h00040;
        exp_q.push_back(25'h000_0040);
        @(negedge clk);
        wait_req("rst_mid");
        adpcma_roe_n = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_mid_req_async", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 8'h99;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_da", {24'd0, adpcma_data}, 32'd0);

        // Address change while A is in flight
        adpcma_bank  = 4'h3;
        adpcma_addr  = 20'h00100;
        adpcma_roe_n = 1'b0;
        exp_q.push_back(25'h030_0100);
        @(negedge clk);
        wait_req("fl1");
        adpcma_addr = 20'h00200;
        exp_q.push_back(25'h030_0200);
        do_ack("fl1", 8'hA1, 2);
        check("fl1_data", {24'd0, adpcma_data}, 32'hA1);
        @(negedge clk);
        wait_req("fl2");
        do_ack("fl2", 8'hB2, 1);
        check("fl2_data", {24'd0, adpcma_data}, 32'hB2);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
